// File: rtl/rms_pkg.sv
// Shared widths and constants for the windowed mean-square front end.
// Optional RMS_ROUND_EN: round-half-up mean instead of truncation.
package rms_pkg;

    localparam int SAMPLE_BITS_DEF = 8;
    localparam int LOG2_WINDOW_DEF = 4;
    localparam int WCNT_BITS       = 16;

    localparam int SQ_BITS     = 2*SAMPLE_BITS_DEF-1;
    localparam int ACC_BITS    = SQ_BITS+LOG2_WINDOW_DEF;
    localparam int WINDOW_LAST = (1 << LOG2_WINDOW_DEF)-1;

    typedef enum logic [1:0] {
        ACT_HOLD,
        ACT_ADD,
        ACT_CLOSE,
        ACT_CLEAR
    } acc_act_e;

    function automatic int sq_bits(input int s);
        return 2*s-1;
    endfunction

    function automatic int acc_bits(input int s, input int l);
        return 2*s-1+l;
    endfunction

    function automatic int cnt_bits(input int l);
        return (l == 0) ? 1 : l;
    endfunction

    function automatic int window_last(input int l);
        return (1 << l)-1;
    endfunction

    // Half of the window, added before the shift to round half up.
    function automatic int round_const(input int l);
        return (l == 0) ? 0 : (1 << (l-1));
    endfunction

endpackage

// File: rtl/rms_window_accumulator_square_stage.sv
// Stage 1: registered signed squarer with a valid flop.
// A synchronous clear drops the sample presented in that cycle.
module square_stage
    import rms_pkg::*;
#(
    parameter int SAMPLE_BITS = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         clear,
    input  logic                         sample_valid,
    input  logic signed [SAMPLE_BITS-1:0] sample,
    output logic                         sq_valid,
    output logic [2*SAMPLE_BITS-2:0]     sq
);

    localparam int SQ_W = sq_bits(SAMPLE_BITS);

    logic signed [2*SAMPLE_BITS-1:0] s_ext;
    logic signed [2*SAMPLE_BITS-1:0] prod;
    logic [SQ_W-1:0]                 sq_d;
    logic [SQ_W-1:0]                 sq_q;
    logic                            vld_d;
    logic                            vld_q;

    assign s_ext = {{SAMPLE_BITS{sample[SAMPLE_BITS-1]}}, sample};
    assign prod  = s_ext * s_ext;

    // Top bit of the square is always 0 (max is 2^(2S-2)).
    assign sq_d  = prod[SQ_W-1:0];
    assign vld_d = sample_valid & ~clear;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= 1'b0;
            sq_q  <= '0;
        end else begin
            vld_q <= vld_d;
            if (vld_d) begin
                sq_q <= sq_d;
            end
        end
    end

    assign sq_valid = vld_q;
    assign sq       = sq_q;

    logic unused_ok;
    assign unused_ok = prod[2*SAMPLE_BITS-1];

endmodule

// File: rtl/rms_window_accumulator.sv
// Squares signed samples and emits the mean square of each 2^L window.
// Optional RMS_ROUND_EN: round-half-up mean instead of truncation.
module rms_window_accumulator
    import rms_pkg::*;
#(
    parameter int SAMPLE_BITS = 8,
    parameter int LOG2_WINDOW = 4,
    parameter int INPUT_BITS  = 2*SAMPLE_BITS
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          clear,
    input  logic                          sample_valid,
    input  logic signed [SAMPLE_BITS-1:0] sample,
    output logic                          start,
    output logic [INPUT_BITS-1:0]         radicand,
    output logic [WCNT_BITS-1:0]          window_count
);

    localparam int SQ_W  = sq_bits(SAMPLE_BITS);
    localparam int ACC_W = acc_bits(SAMPLE_BITS, LOG2_WINDOW);
    localparam int CNT_W = cnt_bits(LOG2_WINDOW);

    localparam logic [CNT_W-1:0] LAST =
        CNT_W'(window_last(LOG2_WINDOW));

`ifdef RMS_ROUND_EN
    localparam logic [ACC_W:0] RND =
        (ACC_W+1)'(round_const(LOG2_WINDOW));
`else
    localparam logic [ACC_W:0] RND = '0;
`endif

    logic                  sq_valid;
    logic [SQ_W-1:0]       sq;

    logic [ACC_W-1:0]      acc_q, acc_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  start_q, start_d;
    logic [INPUT_BITS-1:0] rad_q, rad_d;
    logic [WCNT_BITS-1:0]  wc_q, wc_d;

    logic [ACC_W:0]        sum;
    logic [ACC_W:0]        rounded;
    logic [ACC_W:0]        mean;
    acc_act_e              act;

    square_stage #(
        .SAMPLE_BITS (SAMPLE_BITS)
    ) u_sq (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear        (clear),
        .sample_valid (sample_valid),
        .sample       (sample),
        .sq_valid     (sq_valid),
        .sq           (sq)
    );

    assign sum     = {1'b0, acc_q} + (ACC_W+1)'(sq);
    assign rounded = sum + RND;
    assign mean    = rounded >> LOG2_WINDOW;

    // Clear outranks a window close arriving in the same cycle.
    always_comb begin
        act = ACT_HOLD;
        if (clear) begin
            act = ACT_CLEAR;
        end else if (sq_valid && (cnt_q == LAST)) begin
            act = ACT_CLOSE;
        end else if (sq_valid) begin
            act = ACT_ADD;
        end
    end

    always_comb begin
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        start_d = 1'b0;
        rad_d   = rad_q;
        wc_d    = wc_q;
        unique case (act)
            ACT_CLEAR: begin
                acc_d = '0;
                cnt_d = '0;
            end
            ACT_CLOSE: begin
                acc_d   = '0;
                cnt_d   = '0;
                start_d = 1'b1;
                rad_d   = INPUT_BITS'(mean);
                wc_d    = wc_q + 1'b1;
            end
            ACT_ADD: begin
                acc_d = sum[ACC_W-1:0];
                cnt_d = cnt_q + 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            start_q <= 1'b0;
            rad_q   <= '0;
            wc_q    <= '0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            rad_q   <= rad_d;
            wc_q    <= wc_d;
        end
    end

    assign start        = start_q;
    assign radicand     = rad_q;
    assign window_count = wc_q;

endmodule
